booth_r4_seq_mult: RTL and testbench

Iterative radix-4 Booth signed multiplier.
- Multiplies a WIDTH-bit two's-complement multiplicand by a WIDTH-bit two's-complement multiplier.
- Retires one Booth digit per clock and returns a 2·WIDTH-bit product.
- Sits directly downstream of the 8→9-bit negation converter and takes its output (−M, 9 bits) as the source of the negative partial products.
- Uses a valid/ready handshake on both the operand side and the result side.

---
 rtl/booth_pkg.sv | 33 +++
 rtl/booth_r4_pp_sel.sv | 27 ++
 rtl/booth_r4_seq_mult.sv | 110 +++++++++++
 tb/tb_booth_r4_seq_mult.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier:
// FSM state encoding, Booth digit encoding and the group-to-digit decode.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_e;

    // Radix-4 Booth recoding of the group {q[1], q[0], q[-1]}
    function automatic digit_e booth_digit(input logic [2:0] grp);
        digit_e d;
        case (grp)
            3'b000, 3'b111: d = ZERO;
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Partial-product selector: picks 0, +-M or +-2M for one Booth digit.
// All operands are WIDTH+2 bits so +-2M never overflows.
module booth_r4_pp_sel
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       grp,
    input  logic [WIDTH+1:0] m_pos,
    input  logic [WIDTH+1:0] m_neg,
    output logic [WIDTH+1:0] pp
);

    // Digit decode and operand mux; doubling is a 1-bit left shift in-width
    always_comb begin
        pp = '0;
        case (booth_digit(grp))
            ZERO:    pp = '0;
            POS1:    pp = m_pos;
            POS2:    pp = {m_pos[WIDTH:0], 1'b0};
            NEG1:    pp = m_neg;
            NEG2:    pp = {m_neg[WIDTH:0], 1'b0};
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth signed multiplier, one digit per clock.
// -M normally arrives from the upstream negation converter on i_mcand_neg.
// Define BOOTH_NEG_INTERNAL_EN to ignore that port and negate M internally.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH:0]     i_mcand_neg,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int ITERS = WIDTH / 2;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int XW    = WIDTH + 2;

    state_e           state;
    logic [XW-1:0]    m_pos;
    logic [XW-1:0]    m_neg;
    logic [XW-1:0]    acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [CW-1:0]    cnt;

    logic [XW-1:0]       m_ext;
    logic [XW-1:0]       m_neg_ld;
    logic [XW-1:0]       pp;
    logic [XW-1:0]       sum;
    logic [XW+WIDTH:0]   shifted;
    logic                last_iter;

    assign m_ext = {{2{i_mcand[WIDTH-1]}}, i_mcand};

`ifdef BOOTH_NEG_INTERNAL_EN
    logic unused_mcand_neg;
    assign unused_mcand_neg = ^i_mcand_neg;
    assign m_neg_ld = -m_ext;
`else
    assign m_neg_ld = {i_mcand_neg[WIDTH], i_mcand_neg};
`endif

    booth_r4_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
        .grp   ({q[1:0], q_m1}),
        .m_pos (m_pos),
        .m_neg (m_neg),
        .pp    (pp)
    );

    // One Booth step: add the partial product, then arithmetic shift {A,Q,q-1} by 2
    always_comb begin
        sum       = acc + pp;
        shifted   = $signed({sum, q, q_m1}) >>> 2;
        last_iter = (cnt == CW'(ITERS - 1));
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    // Handshake FSM and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            m_pos     <= '0;
            m_neg     <= '0;
            acc       <= '0;
            q         <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            o_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        m_pos <= m_ext;
                        m_neg <= m_neg_ld;
                        acc   <= '0;
                        q     <= i_mplier;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc  <= shifted[XW+WIDTH:WIDTH+1];
                    q    <= shifted[WIDTH:1];
                    q_m1 <= shifted[0];
                    cnt  <= cnt + CW'(1);
                    if (last_iter) begin
                        // low WIDTH bits of A above the final Q form the product
                        o_product <= shifted[2*WIDTH:1];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Scoreboard bench for booth_r4_seq_mult (WIDTH = 8).
// Driver pushes the arithmetic product M*Q on each accept; the monitor pops
// and compares on every result handshake. Directed checks cover latency,
// stall hold, initiation interval and reset abort.
module tb_booth_r4_seq_mult;

    localparam int W  = 8;
    localparam int TP = 10;

    logic           clk;
    logic           i_rst;
    logic           i_valid;
    logic           o_ready;
    logic [W-1:0]   i_mcand;
    logic [W:0]     i_mcand_neg;
    logic [W-1:0]   i_mplier;
    logic           o_valid;
    logic           i_ready;
    logic [2*W-1:0] o_product;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] sb[$];
    bit  rand_phase = 0;
    bit  rand_done  = 0;

    booth_r4_seq_mult #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_mcand     (i_mcand),
        .i_mcand_neg (i_mcand_neg),
        .i_mplier    (i_mplier),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_product   (o_product)
    );

    initial clk = 0;
    always #(TP/2) clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
        int a, b;
        a = $signed(m);
        b = $signed(q);
        return 16'(a * b);
    endfunction

    function automatic logic [W:0] neg9(input logic [W-1:0] m);
        int a;
        a = $signed(m);
        return 9'(-a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted result against the scoreboard head
    always @(negedge clk) begin
        if (!i_rst && o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result: got %0h expected none", o_product);
            end else begin
                logic [2*W-1:0] e;
                e = sb.pop_front();
                if (o_product !== e) begin
                    failures++;
                    $display("FAIL product: got %0h expected %0h", o_product, e);
                end
            end
        end
    end

    // Present operands until accepted; push the model result on the accept edge
    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [W:0] neg, output time t_acc);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!o_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ready) begin
            chk("accept_timeout", 0, 1);
            t_acc = 0;
            return;
        end
        i_valid     = 1;
        i_mcand     = m;
        i_mplier    = q;
        i_mcand_neg = neg;
        @(posedge clk);
        t_acc = $time;
        sb.push_back(ref_mul(m, q));
        #1;
        i_valid     = 0;
        i_mcand     = W'($urandom);
        i_mplier    = W'($urandom);
        i_mcand_neg = (W+1)'($urandom);
    endtask

    // Cycles from the accept edge until o_valid is seen
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!o_valid && n < 40);
        if (!o_valid) chk("valid_timeout", 0, 1);
    endtask

    // Random backpressure during the sweep
    initial begin
        wait (rand_phase);
        while (!rand_done) begin
            @(posedge clk); #1;
            i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        time t0, t1;
        int  lat, n;
        logic [W-1:0] m, q;

        i_rst = 1; i_valid = 0; i_ready = 1;
        i_mcand = '0; i_mplier = '0; i_mcand_neg = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_ready", o_ready, 1);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_product", o_product, 0);
        i_rst = 0;

        // 7 * -3, latency 4
        issue(8'd7, 8'hFD, 9'h1F9, t0);
        wait_valid(lat);
        chk("latency", lat, 4);
        chk("p_7x-3", o_product, 16'hFFEB);

        // extreme negatives
        issue(8'h80, 8'h80, 9'h080, t0);
        wait_valid(lat);
        chk("p_-128x-128", o_product, 16'h4000);
        issue(8'h80, 8'h7F, 9'h080, t0);
        wait_valid(lat);
        chk("p_-128x127", o_product, 16'hC080);

        // stall with i_ready low, i_valid pulses ignored
        @(posedge clk); #1;
        i_ready = 0;
        issue(8'd127, 8'd127, 9'h181, t0);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            chk("stall_product", o_product, 16'h3F01);
            chk("stall_valid", o_valid, 1);
            chk("stall_ready", o_ready, 0);
            i_valid  = i[0];
            i_mcand  = W'($urandom);
            i_mplier = W'($urandom);
            @(posedge clk); #1;
        end
        i_valid = 0;
        i_ready = 1;
        @(posedge clk); #1;
        chk("release_idle", o_ready, 1);

        // zero operands back-to-back, initiation interval
        issue(8'd0, 8'h55, 9'h000, t0);
        issue(8'h55, 8'd0, neg9(8'h55), t1);
        chk("init_interval", 32'((t1 - t0) / TP), 6);
        wait_valid(lat);
        @(posedge clk); #1;

        // reset during the second CALC cycle
        issue(8'd33, 8'd44, neg9(8'd33), t0);
        @(posedge clk); #1;
        i_rst = 1;
        @(posedge clk); #1;
        i_rst = 0;
        sb.delete();
        chk("abort_o_ready", o_ready, 1);
        chk("abort_o_valid", o_valid, 0);
        chk("abort_o_product", o_product, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_valid) n++;
            @(posedge clk); #1;
        end
        chk("abort_no_stale", n, 0);

`ifdef BOOTH_NEG_INTERNAL_EN
        issue(8'd5, 8'd9, 9'h000, t0);
        wait_valid(lat);
        chk("internal_neg", o_product, 16'h002D);
        @(posedge clk); #1;
`endif

        // randomized sweep with random backpressure
        rand_phase = 1;
        for (int i = 0; i < 300; i++) begin
            m = W'($urandom);
            q = W'($urandom);
            if (i < 8) q = (i[0]) ? 8'h80 : 8'h7F;
            issue(m, q, neg9(m), t0);
        end
        rand_done = 1;
        @(posedge clk); #1;
        i_ready = 1;
        n = 0;
        while ((sb.size() != 0 || o_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        chk("drain_idle", o_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
